// File: rtl/data_connection_block_sc.sv
// Serially configured, double-buffered data connection block: scan-chain shadow register,
// commit to active routing. Define DCB_OUTPUT_REG_EN to register data_input (1-cycle latency).
module data_connection_block_sc #(
   parameter int W       = 16,
   parameter int WW      = 4,
   parameter int DATAIN  = 4,
   parameter int DATAOUT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [W-1:0]          north_in,
   input  logic [W-1:0]          south_in,
   output logic [W-1:0]          north_out,
   output logic [W-1:0]          south_out,
   output logic [WW*DATAIN-1:0]  data_input,
   input  logic [WW*DATAOUT-1:0] data_output,
   input  logic                  cfg_in,
   input  logic                  cfg_en,
   input  logic                  cfg_commit,
   input  logic                  cfg_abort,
   output logic                  cfg_out,
   output logic                  cfg_loaded,
   output logic                  cfg_err
);
   // state     | meaning
   // S_EMPTY   | no bits shifted since reset/commit/abort
   // S_SHIFTING| 1..CFG_BITS-1 bits shifted
   // S_LOADED  | exactly CFG_BITS bits shifted, commit allowed
   // S_OVERRUN | more than CFG_BITS bits shifted, error raised

   localparam int NGRP        = 2 * W / WW;
   localparam int SEL_PER_IN  = $clog2(NGRP);
   localparam int SEL_PER_OUT = $clog2(DATAOUT + 1);
   localparam int IN_BITS     = SEL_PER_IN * DATAIN * WW;
   localparam int CFG_BITS    = IN_BITS + 2 * W * SEL_PER_OUT;
   localparam int CNT_W       = $clog2(CFG_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CFG_BITS + 1);

   typedef enum logic [1:0] {
      S_EMPTY    = 2'd0,
      S_SHIFTING = 2'd1,
      S_LOADED   = 2'd2,
      S_OVERRUN  = 2'd3
   } state_t;

   state_t               state_q, state_nxt;
   logic [CNT_W-1:0]     cnt_q, cnt_nxt;
   logic                 err_q, err_nxt;
   logic                 do_shift, do_commit;
   logic [CFG_BITS-1:0]  shadow_q;
   logic [CFG_BITS-1:0]  active_q;
   logic [WW*DATAIN-1:0] din_comb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_EMPTY;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         err_q   <= err_nxt;
      end
   end

   // abort beats commit beats shift
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      err_nxt   = err_q;
      do_shift  = 1'b0;
      do_commit = 1'b0;
      if (cfg_abort) begin
         state_nxt = S_EMPTY;
         cnt_nxt   = '0;
         err_nxt   = 1'b0;
      end else if (cfg_commit) begin
         if (state_q == S_LOADED) begin
            do_commit = 1'b1;
            state_nxt = S_EMPTY;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
         end else begin
            err_nxt = 1'b1;
         end
      end else if (cfg_en) begin
         do_shift = 1'b1;
         case (state_q)
            S_LOADED: begin
               state_nxt = S_OVERRUN;
               cnt_nxt   = CNT_OVER;
               err_nxt   = 1'b1;
            end
            S_OVERRUN: begin
               state_nxt = S_OVERRUN;
            end
            default: begin
               cnt_nxt   = cnt_q + CNT_W'(1);
               state_nxt = ((cnt_q + CNT_W'(1)) == CNT_FULL) ? S_LOADED : S_SHIFTING;
            end
         endcase
      end
   end

   always_comb begin
      cfg_loaded = (state_q == S_LOADED);
      cfg_err    = err_q;
      cfg_out    = shadow_q[0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (do_shift) begin
            shadow_q <= {cfg_in, shadow_q[CFG_BITS-1:1]};
         end
         if (do_commit) begin
            active_q <= shadow_q;
         end
      end
   end

   // Selector k: even -> north group k/2, odd -> south group k/2, beyond the groups -> 0
   function automatic logic in_mux(input logic [SEL_PER_IN-1:0] k, input int j,
                                   input logic [W-1:0] n, input logic [W-1:0] s);
      int         kk;
      logic [W-1:0] t;
      kk = int'(k);
      if (kk >= NGRP) begin
         return 1'b0;
      end
      t = (kk % 2 == 0) ? (n >> ((kk / 2) * WW + j)) : (s >> ((kk / 2) * WW + j));
      return t[0];
   endfunction

   // Selector k: 0 or out of range -> pass-through track, else logic-block word k-1
   function automatic logic out_mux(input logic [SEL_PER_OUT-1:0] k, input int i,
                                    input logic [W-1:0] pass,
                                    input logic [WW*DATAOUT-1:0] dout);
      int                  kk;
      logic [W-1:0]        tp;
      logic [WW*DATAOUT-1:0] td;
      kk = int'(k);
      if (kk == 0 || kk > DATAOUT) begin
         tp = pass >> i;
         return tp[0];
      end
      td = dout >> ((kk - 1) * WW + (i % WW));
      return td[0];
   endfunction

   for (genvar gi = 0; gi < DATAIN; gi++) begin : g_word
      for (genvar gj = 0; gj < WW; gj++) begin : g_lane
         assign din_comb[gi*WW+gj] =
            in_mux(active_q[(gi*WW+gj)*SEL_PER_IN +: SEL_PER_IN], gj, north_in, south_in);
      end
   end

   for (genvar gt = 0; gt < W; gt++) begin : g_track
      assign north_out[gt] =
         out_mux(active_q[IN_BITS + gt*2*SEL_PER_OUT +: SEL_PER_OUT], gt, south_in, data_output);
      assign south_out[gt] =
         out_mux(active_q[IN_BITS + gt*2*SEL_PER_OUT + SEL_PER_OUT +: SEL_PER_OUT], gt,
                 north_in, data_output);
   end

`ifdef DCB_OUTPUT_REG_EN
   logic [WW*DATAIN-1:0] din_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         din_q <= '0;
      end else begin
         din_q <= din_comb;
      end
   end

   assign data_input = din_q;
`else
   assign data_input = din_comb;
`endif

endmodule
